// File: rtl/lane_buffer.sv
// lane_buffer: DEPTH lanes of WIDTH bits with whole-lane load, single-bit
// write, registered single-bit read and a serial scan engine that streams one
// lane out a bit per cycle.
// Optional feature macro LANE_BUF_REVERSE_EN: when defined, logical bit index
// i addresses physical bit WIDTH-1-i; otherwise logical and physical match.
// line_in and lane_out are always in physical bit order.
module lane_buffer #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 5,
  parameter int IW    = 5,
  parameter int LW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [LW-1:0]    lane_sel,
  input  logic [WIDTH-1:0] line_in,
  input  logic [IW-1:0]    index,
  input  logic             wr,
  input  logic             wbit,
  input  logic             rd,
  output logic             rbit,
  output logic             rvalid,
  input  logic             scan_start,
  output logic             scan_bit,
  output logic             scan_valid,
  output logic             scan_done,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [WIDTH-1:0] lane_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // One extra bit so the range checks cannot alias when 2^LW == DEPTH etc.
  localparam logic [LW:0]   DEPTH_C  = (LW+1)'(DEPTH);
  localparam logic [IW:0]   WIDTH_C  = (IW+1)'(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  // Logical-to-physical bit index map.
  function automatic logic [IW-1:0] map_idx(input logic [IW-1:0] i);
`ifdef LANE_BUF_REVERSE_EN
    return LAST_IDX - i;
`else
    return i;
`endif
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [1:0]       state;
  logic [IW-1:0]    cnt;
  logic [LW-1:0]    scan_lane;

  logic             lane_ok;
  logic             idx_ok;
  logic [LW-1:0]    lane_idx;
  logic [IW-1:0]    phys;
  logic [IW-1:0]    cnt_nxt;
  logic             start_ok;
  logic             scan_conflict;
  logic             init_err;
  logic             wr_err;
  logic             rd_err;
  logic             start_err;
  logic             do_init;
  logic             do_wr;
  logic             do_rd;

  // Operand validation and per-operation accept/error decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    lane_ok  = ({1'b0, lane_sel} < DEPTH_C);
    idx_ok   = ({1'b0, index} < WIDTH_C);
    lane_idx = lane_ok ? lane_sel : '0;
    phys     = map_idx(index);
    cnt_nxt  = cnt + 1'b1;

    // A new scan may start from IDLE or from the DONE cycle.
    start_ok = scan_start && lane_ok && (state != S_SCAN);

    // The lane being streamed is frozen; a scan accepted this very edge
    // freezes lane_sel too, so its first beat and later beats agree.
    scan_conflict = ((state == S_SCAN) && (lane_idx == scan_lane)) || start_ok;

    init_err  = init && (!lane_ok || scan_conflict);
    // init shadows wr entirely (same lane), so wr raises no error then.
    wr_err    = wr && !init && (!lane_ok || !idx_ok || scan_conflict);
    rd_err    = rd && (!lane_ok || !idx_ok);
    start_err = scan_start && !start_ok;

    do_init = init && !init_err;
    do_wr   = wr && !init && !wr_err;
    do_rd   = rd && !rd_err;

    lane_out = lane_ok ? mem[lane_idx] : '0;
  end

  assign busy = (state != S_IDLE);

  // Lane storage: whole-lane load has priority over single-bit write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the lanes must read as zero straight after reset, so this
      // array is deliberately reset (which rules out a RAM macro).
      for (int l = 0; l < DEPTH; l++) begin
        mem[l] <= '0;
      end
    end else if (do_init) begin
      // NOTE: state uses non-blocking assignment so reads elsewhere in the
      // same edge (rd, scan) see the pre-write value.
      mem[lane_idx] <= line_in;
    end else if (do_wr) begin
      mem[lane_idx][phys] <= wbit;
    end
  end

  // Registered single-bit read; rbit holds between valid reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbit   <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= do_rd;
      if (do_rd) begin
        rbit <= mem[lane_idx][phys];
      end
    end
  end

  // Sticky error flag; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (init_err || wr_err || rd_err || start_err) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Scan engine: beats are registered, each loaded one edge ahead of use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      scan_lane  <= '0;
      scan_bit   <= 1'b0;
      scan_valid <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state      <= S_SCAN;
            scan_lane  <= lane_idx;
            cnt        <= '0;
            scan_bit   <= mem[lane_idx][map_idx('0)];
            scan_valid <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (cnt == LAST_IDX) begin
            state      <= S_DONE;
            scan_bit   <= 1'b0;
            scan_valid <= 1'b0;
            scan_done  <= 1'b1;
          end else begin
            cnt      <= cnt_nxt;
            scan_bit <= mem[scan_lane][map_idx(cnt_nxt)];
          end
        end
        default: begin
          state      <= S_IDLE;
          scan_bit   <= 1'b0;
          scan_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_buffer.sv
// Directed bench for lane_buffer: a lane model supplies expected read data and
// scan beats through queues that are popped as the DUT produces output.
module tb_lane_buffer;

  localparam int WIDTH = 25;
  localparam int DEPTH = 5;
  localparam int IW    = 5;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init = 1'b0;
  logic [LW-1:0]    lane_sel = '0;
  logic [WIDTH-1:0] line_in = '0;
  logic [IW-1:0]    index = '0;
  logic             wr = 1'b0;
  logic             wbit = 1'b0;
  logic             rd = 1'b0;
  logic             rbit;
  logic             rvalid;
  logic             scan_start = 1'b0;
  logic             scan_bit;
  logic             scan_valid;
  logic             scan_done;
  logic             busy;
  logic             err;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] lane_out;

  lane_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .init(init), .lane_sel(lane_sel), .line_in(line_in),
    .index(index), .wr(wr), .wbit(wbit), .rd(rd), .rbit(rbit), .rvalid(rvalid),
    .scan_start(scan_start), .scan_bit(scan_bit), .scan_valid(scan_valid),
    .scan_done(scan_done), .busy(busy), .err(err), .err_clr(err_clr),
    .lane_out(lane_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic             rd_q[$];
  logic             scan_q[$];
  logic [WIDTH-1:0] m [DEPTH];

  function automatic int mp(input int i);
`ifdef LANE_BUF_REVERSE_EN
    return WIDTH - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int l = 0; l < DEPTH; l++) m[l] = '0;
    rd_q.delete();
    scan_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {rbit, rvalid, scan_bit, scan_valid, scan_done, busy, err}, 0);
    for (int l = 0; l < DEPTH; l++) begin
      lane_sel = LW'(l);
      #1;
      chk({tag, "_lane_out"}, lane_out, 0);
    end
  endtask

  task automatic do_init(input int lane, input logic [WIDTH-1:0] val);
    lane_sel = LW'(lane); line_in = val; init = 1'b1;
    tick();
    init = 1'b0;
    m[lane] = val;
    chk("init_lane_out", lane_out, m[lane]);
  endtask

  task automatic do_rd(input string tag, input int lane, input int idx);
    lane_sel = LW'(lane); index = IW'(idx); rd = 1'b1;
    rd_q.push_back(m[lane][mp(idx)]);
    tick();
    rd = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rbit"}, rbit, rd_q.pop_front());
  endtask

  // Runs one complete scan of lane; inject adds traffic during the scan.
  task automatic run_scan(input int lane, input bit inject);
    for (int c = 0; c < WIDTH; c++) scan_q.push_back(m[lane][mp(c)]);
    lane_sel = LW'(lane); scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int cyc = 1; cyc <= WIDTH + 1; cyc++) begin
      chk("scan_busy", busy, 1);
      if (cyc <= WIDTH) begin
        chk("scan_valid", scan_valid, 1);
        chk("scan_bit", scan_bit, scan_q.pop_front());
        chk("scan_done_early", scan_done, 0);
      end else begin
        chk("scan_valid_end", scan_valid, 0);
        chk("scan_done", scan_done, 1);
      end
      if (inject) begin
        case (cyc)
          3: begin  // write into the lane under scan: must be refused
            lane_sel = LW'(lane); index = '0; wbit = ~m[lane][mp(0)]; wr = 1'b1;
          end
          4: begin
            wr = 1'b0;
            chk("wr_scan_lane_err", err, 1);
            chk("wr_scan_lane_kept", lane_out, m[lane]);
            err_clr = 1'b1;
          end
          5: begin  // write into another lane: allowed
            err_clr = 1'b0;
            chk("err_clr_mid_scan", err, 0);
            lane_sel = 3'd3; index = '0; wbit = 1'b1; wr = 1'b1;
            m[3][mp(0)] = 1'b1;
          end
          6: begin  // read the lane under scan: allowed
            wr = 1'b0;
            chk("wr_other_lane", lane_out, m[3]);
            chk("wr_other_no_err", err, 0);
            lane_sel = LW'(lane); index = '0; rd = 1'b1;
            rd_q.push_back(m[lane][mp(0)]);
          end
          7: begin  // second scan_start while scanning
            rd = 1'b0;
            chk("rd_scan_lane_rvalid", rvalid, 1);
            chk("rd_scan_lane_rbit", rbit, rd_q.pop_front());
            lane_sel = 3'd0; scan_start = 1'b1;
          end
          8: begin
            scan_start = 1'b0;
            chk("start_busy_err", err, 1);
            err_clr = 1'b1;
          end
          9: begin
            err_clr = 1'b0;
            chk("start_busy_clr", err, 0);
          end
          default: ;
        endcase
      end
      tick();
    end
    chk("scan_idle_busy", busy, 0);
    chk("scan_done_pulse", scan_done, 0);
  endtask

  initial begin
    logic prev_rbit;
    clear_model();

    // Reset state.
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Load lane 2, read logical 24 then logical 0.
    do_init(2, 25'h0000001);
    do_rd("rd_l2_i24", 2, 24);
    do_rd("rd_l2_i0", 2, 0);
    tick();
    chk("rvalid_one_cycle", rvalid, 0);

    // Single-bit write then read back.
    lane_sel = 3'd1; index = 5'd3; wbit = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0;
    m[1][mp(3)] = 1'b1;
    do_rd("rd_l1_i3", 1, 3);
    lane_sel = 3'd1;
    #1;
    chk("lane1_out", lane_out, m[1]);

    // init and wr together: init wins, no error.
    lane_sel = 3'd4; line_in = 25'h0F0F0F0; init = 1'b1;
    index = '0; wbit = 1'b1; wr = 1'b1;
    tick();
    init = 1'b0; wr = 1'b0;
    m[4] = 25'h0F0F0F0;
    chk("init_over_wr", lane_out, m[4]);
    chk("init_over_wr_err", err, 0);

    // Out-of-range index on rd.
    prev_rbit = rbit;
    lane_sel = 3'd0; index = 5'd25; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("rd_i25_rvalid", rvalid, 0);
    chk("rd_i25_rbit", rbit, prev_rbit);
    chk("rd_i25_err", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", err, 0);

    // Out-of-range lane on init, and error beating err_clr.
    lane_sel = 3'd5; line_in = '1; init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_l5_err", err, 1);
    lane_sel = 3'd0; index = 5'd30; rd = 1'b1; err_clr = 1'b1;
    tick();
    rd = 1'b0; err_clr = 1'b0;
    chk("err_beats_clr", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr2", err, 0);
    for (int l = 0; l < DEPTH; l++) begin
      lane_sel = LW'(l);
      #1;
      chk("lanes_intact", lane_out, m[l]);
    end

    // Scan lane 2 with interfering traffic.
    run_scan(2, 1'b1);
    lane_sel = 3'd3;
    #1;
    chk("lane3_after_scan", lane_out, m[3]);

    // Leave rbit = 1 so reset clearing it is visible.
    do_rd("rd_set_rbit", 2, mp(0));

    // Reset in the middle of a scan of lane 1.
    do_init(1, 25'h0AAAAAA);
    for (int c = 0; c < WIDTH; c++) scan_q.push_back(m[1][mp(c)]);
    lane_sel = 3'd1; scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      chk("rscan_valid", scan_valid, 1);
      chk("rscan_bit", scan_bit, scan_q.pop_front());
      if (cyc == 3) begin
        index = 5'd31; rd = 1'b1;
      end
      if (cyc == 4) begin
        rd = 1'b0;
        chk("rscan_err_set", err, 1);
      end
      if (cyc < 10) tick();
    end
    rst = 1'b0;
    #1;
    clear_model();
    check_all_zero("mid_scan_reset");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_done_after_reset", {scan_done, busy}, 0);
    end

    // Scan after reset behaves normally.
    do_init(0, 25'h1555555);
    run_scan(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time in case the DUT stalls the directed sequence.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
